// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// hazard controller (slave): register indices and hazard sources in, stall/flush controls out.
interface pipeline_hazard_controller_if #(
  parameter int WIDTH        = 16,
  parameter int ADDRESSWIDTH = 4
);
  logic [ADDRESSWIDTH-1:0] rs1D;
  logic [ADDRESSWIDTH-1:0] rs2D;
  logic                    rs1ValidD;
  logic                    rs2ValidD;
  logic [ADDRESSWIDTH-1:0] rdE;
  logic                    memReadE;
  logic                    takeBranchE;
  logic                    memAccessM;
  logic                    stallF;
  logic                    stallD;
  logic                    stallE;
  logic                    stallM;
  logic                    flushD;
  logic                    flushE;
  logic                    memBusy;
  logic [WIDTH-1:0]        stallCount;

  modport master (
    output rs1D, rs2D, rs1ValidD, rs2ValidD, rdE, memReadE, takeBranchE, memAccessM,
    input  stallF, stallD, stallE, stallM, flushD, flushE, memBusy, stallCount
  );

  modport slave (
    input  rs1D, rs2D, rs1ValidD, rs2ValidD, rdE, memReadE, takeBranchE, memAccessM,
    output stallF, stallD, stallE, stallM, flushD, flushE, memBusy, stallCount
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencing for the 5-stage pipeline: shared-memory port arbitration,
// taken-branch flushes, load-use interlocks and a saturating stall-cycle counter.
module pipeline_hazard_controller #(
  parameter int WIDTH        = 16,
  parameter int ADDRESSWIDTH = 4,
  parameter int MEMLATENCY   = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  pipeline_hazard_controller_if.slave  hz
);

  localparam int WCW = (MEMLATENCY > 1) ? $clog2(MEMLATENCY) : 1;
  localparam logic [WCW-1:0] WAIT_INIT = (MEMLATENCY >= 2) ? WCW'(MEMLATENCY - 2) : '0;
  localparam logic [WIDTH-1:0] COUNT_MAX = '1;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    MEMLAST = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WCW-1:0]   wait_count_reg, wait_count_next;
  logic [WIDTH-1:0] stall_count_reg;

  logic load_use;
  logic mem_stall;
  logic mem_busy;
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, busy_out;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= RUN;
      wait_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      wait_count_reg <= wait_count_next;
    end
  end

  assign load_use = hz.memReadE &
                    ((hz.rs1ValidD & (hz.rs1D == hz.rdE)) |
                     (hz.rs2ValidD & (hz.rs2D == hz.rdE)));

  always_comb begin
    state_next      = state_reg;
    wait_count_next = wait_count_reg;
    mem_stall       = 1'b0;
    mem_busy        = 1'b0;

    unique case (state_reg)
      RUN: begin
        if (hz.memAccessM) begin
          mem_busy = 1'b1;
          // A single-cycle access never holds the pipeline, so the FSM stays put.
          if (MEMLATENCY >= 2) begin
            mem_stall       = 1'b1;
            wait_count_next = WAIT_INIT;
            state_next      = (MEMLATENCY > 2) ? MEMWAIT : MEMLAST;
          end
        end
      end
      MEMWAIT: begin
        mem_stall       = 1'b1;
        mem_busy        = 1'b1;
        wait_count_next = wait_count_reg - 1'b1;
        if (wait_count_reg <= WCW'(1)) begin
          state_next = MEMLAST;
        end
      end
      MEMLAST: begin
        // Release cycle: the access still owns the port but the pipeline moves.
        mem_busy   = 1'b1;
        state_next = RUN;
      end
      default: begin
        state_next      = RUN;
        wait_count_next = '0;
      end
    endcase
  end

  always_comb begin
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_e  = 1'b0;
    stall_m  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    busy_out = 1'b0;

    // Outputs are masked while reset is held so nothing leaks out combinationally.
    if (reset) begin
      busy_out = mem_busy;
      if (mem_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
      end else if (hz.takeBranchE) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (load_use) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_count_reg <= '0;
    end else if (stall_f && (stall_count_reg != COUNT_MAX)) begin
      stall_count_reg <= stall_count_reg + 1'b1;
    end
  end

  assign hz.stallF     = stall_f;
  assign hz.stallD     = stall_d;
  assign hz.stallE     = stall_e;
  assign hz.stallM     = stall_m;
  assign hz.flushD     = flush_d;
  assign hz.flushE     = flush_e;
  assign hz.memBusy    = busy_out;
  assign hz.stallCount = stall_count_reg;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: directed scenarios plus a
// randomized run scored against a cycle-phase reference model.
module tb_pipeline_hazard_controller;

  localparam int WIDTH  = 4;
  localparam int AW     = 4;
  localparam int ML     = 3;
  localparam int CNTMAX = (1 << WIDTH) - 1;

  logic clock;
  logic reset;

  pipeline_hazard_controller_if #(.WIDTH(WIDTH), .ADDRESSWIDTH(AW)) hif ();

  pipeline_hazard_controller #(
    .WIDTH(WIDTH),
    .ADDRESSWIDTH(AW),
    .MEMLATENCY(ML)
  ) dut (
    .clock(clock),
    .reset(reset),
    .hz(hif.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model: m_phase = cycles since the current access began (-1 = port idle).
  int         m_phase = -1;
  int         m_cnt   = 0;
  int         m_cur   = -1;
  logic [6:0] exp_ctl;
  logic [6:0] act_ctl;

  // {stallF, stallD, stallE, stallM, flushD, flushE, memBusy}
  assign act_ctl = {hif.stallF, hif.stallD, hif.stallE, hif.stallM,
                    hif.flushD, hif.flushE, hif.memBusy};

  task automatic model_eval();
    logic lu;
    exp_ctl = '0;
    m_cur   = m_phase;
    if (reset) begin
      if (m_phase < 0 && hif.memAccessM && ML >= 2) m_cur = 0;
      lu = hif.memReadE && ((hif.rs1ValidD && hif.rs1D == hif.rdE) ||
                            (hif.rs2ValidD && hif.rs2D == hif.rdE));
      if (m_cur >= 0 || (ML == 1 && hif.memAccessM)) exp_ctl[0] = 1'b1;
      if (m_cur >= 0 && m_cur < ML - 1) exp_ctl[6:3] = 4'b1111;
      else if (hif.takeBranchE)         exp_ctl[2:1] = 2'b11;
      else if (lu)                      {exp_ctl[6], exp_ctl[5], exp_ctl[1]} = 3'b111;
    end
  endtask

  task automatic tick();
    model_eval();
    @(posedge clock);
    if (reset) begin
      if (exp_ctl[6] && m_cnt < CNTMAX) m_cnt++;
      if (m_cur >= 0) begin
        m_phase = m_cur + 1;
        if (m_phase >= ML) m_phase = -1;
      end else begin
        m_phase = -1;
      end
    end else begin
      m_phase = -1;
      m_cnt   = 0;
    end
    #2;
  endtask

  task automatic assert_reset();
    reset   = 1'b0;
    m_phase = -1;
    m_cnt   = 0;
  endtask

  task automatic idle_inputs();
    hif.rs1D = '0; hif.rs2D = '0; hif.rs1ValidD = 1'b0; hif.rs2ValidD = 1'b0;
    hif.rdE = '0; hif.memReadE = 1'b0; hif.takeBranchE = 1'b0; hif.memAccessM = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    hif.memAccessM  = 1'b1;
    hif.takeBranchE = 1'b1;
    assert_reset();
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (act_ctl !== 7'b0) begin
        tests_failed++;
        $display("FAIL reset_outputs cycle %0d: got %b, required 0000000", i, act_ctl);
      end
      tests_run++;
      if (hif.stallCount !== '0) begin
        tests_failed++;
        $display("FAIL reset_count cycle %0d: got %0d, required 0", i, hif.stallCount);
      end
      tick();
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if (act_ctl !== 7'b1111001) begin
      tests_failed++;
      $display("FAIL reset_release_stall: got %b, required 1111001", act_ctl);
    end
    for (int i = 0; i < 4; i++) tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_load_use();
    idle_inputs();
    hif.memReadE  = 1'b1;
    hif.rdE       = 4'd5;
    hif.rs1D      = 4'd5;
    hif.rs1ValidD = 1'b1;
    #1;
    tests_run++;
    if (act_ctl !== 7'b1100010) begin
      tests_failed++;
      $display("FAIL load_use_hit: got %b, required 1100010", act_ctl);
    end
    tick();
    hif.rs1ValidD = 1'b0;
    #1;
    tests_run++;
    if (act_ctl !== 7'b0) begin
      tests_failed++;
      $display("FAIL load_use_invalid_rs1: got %b, required 0000000", act_ctl);
    end
    hif.rs2D      = 4'd5;
    hif.rs2ValidD = 1'b1;
    #1;
    tests_run++;
    if (act_ctl !== 7'b1100010) begin
      tests_failed++;
      $display("FAIL load_use_rs2: got %b, required 1100010", act_ctl);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_mem_latency();
    int st[6] = '{1, 1, 0, 1, 1, 0};
    idle_inputs();
    hif.memAccessM = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      tests_run++;
      if (act_ctl !== {{4{st[i][0]}}, 2'b00, 1'b1}) begin
        tests_failed++;
        $display("FAIL mem_seq t+%0d: got %b, required %b", i, act_ctl,
                 {{4{st[i][0]}}, 2'b00, 1'b1});
      end
      tick();
    end
    idle_inputs();
    #1;
    tests_run++;
    if (act_ctl !== 7'b0) begin
      tests_failed++;
      $display("FAIL mem_idle_after: got %b, required 0000000", act_ctl);
    end
    tick();
  endtask

  task automatic test_branch_during_mem();
    int fl[3] = '{0, 0, 1};
    idle_inputs();
    hif.memAccessM  = 1'b1;
    hif.takeBranchE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if ({hif.flushD, hif.flushE, hif.stallF} !== {fl[i][0], fl[i][0], ~fl[i][0]}) begin
        tests_failed++;
        $display("FAIL branch_release t+%0d: flushD/flushE/stallF got %b%b%b, required %b%b%b",
                 i, hif.flushD, hif.flushE, hif.stallF, fl[i][0], fl[i][0], ~fl[i][0]);
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_branch_vs_load_use();
    idle_inputs();
    hif.memReadE    = 1'b1;
    hif.rdE         = 4'd9;
    hif.rs2D        = 4'd9;
    hif.rs2ValidD   = 1'b1;
    hif.takeBranchE = 1'b1;
    #1;
    tests_run++;
    if (act_ctl !== 7'b0000110) begin
      tests_failed++;
      $display("FAIL branch_beats_load_use: got %b, required 0000110", act_ctl);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_saturation();
    idle_inputs();
    assert_reset();
    #1;
    reset = 1'b1;
    hif.memReadE  = 1'b1;
    hif.rdE       = 4'd5;
    hif.rs1D      = 4'd5;
    hif.rs1ValidD = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      tests_run++;
      if (hif.stallCount !== WIDTH'((i < CNTMAX) ? i : CNTMAX)) begin
        tests_failed++;
        $display("FAIL stall_count step %0d: got %0d, required %0d", i, hif.stallCount,
                 (i < CNTMAX) ? i : CNTMAX);
      end
      tick();
    end
    #1;
    tests_run++;
    if (hif.stallCount !== WIDTH'(15)) begin
      tests_failed++;
      $display("FAIL stall_count_sat: got %0d, required 15", hif.stallCount);
    end
    assert_reset();
    #1;
    tests_run++;
    if (hif.stallCount !== '0) begin
      tests_failed++;
      $display("FAIL stall_count_reset: got %0d, required 0", hif.stallCount);
    end
    tick();
    reset = 1'b1;
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 99) < 2) assert_reset();
      hif.rs1D        = AW'($urandom_range(0, 3));
      hif.rs2D        = AW'($urandom_range(0, 3));
      hif.rdE         = AW'($urandom_range(0, 3));
      hif.rs1ValidD   = 1'($urandom_range(0, 1));
      hif.rs2ValidD   = 1'($urandom_range(0, 1));
      hif.memReadE    = 1'($urandom_range(0, 1));
      hif.takeBranchE = ($urandom_range(0, 99) < 20);
      hif.memAccessM  = ($urandom_range(0, 99) < 35);
      #1;
      model_eval();
      tests_run++;
      if (act_ctl !== exp_ctl) begin
        tests_failed++;
        $display("FAIL random_ctl cycle %0d: got %b, required %b", i, act_ctl, exp_ctl);
      end
      tests_run++;
      if (hif.stallCount !== WIDTH'(m_cnt)) begin
        tests_failed++;
        $display("FAIL random_count cycle %0d: got %0d, required %0d", i, hif.stallCount, m_cnt);
      end
      tick();
    end
    reset = 1'b1;
    idle_inputs();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    idle_inputs();
    @(posedge clock);
    #2;
    test_reset();
    test_load_use();
    test_mem_latency();
    test_branch_during_mem();
    test_branch_vs_load_use();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
